// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU data
// port (requester 0) and a loader/debug DMA port (requester 1).
module dmem_arbiter #(
  parameter int AW = 5
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [31:0]   addr0,
  input  logic [31:0]   addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [31:0]   rdata0,
  output logic [31:0]   rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          oor_q, oor_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          any_req;
  logic          win;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          unused_addr_bits;

  // A tie goes to whichever requester was not granted last.
  always_comb begin
    any_req   = req0 | req1;
    win       = (req0 && req1) ? ~last_q : req1;
    sel_we    = win ? we1 : we0;
    sel_addr  = win ? addr1 : addr0;
    sel_wdata = win ? wdata1 : wdata0;
  end

  assign unused_addr_bits = ^sel_addr[1:0];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    oor_d   = oor_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_WAIT: begin
        if (any_req) begin
          state_d = S_ISSUE;
          last_d  = win;
          owner_d = win;
          we_d    = sel_we;
          addr_d  = sel_addr[AW+1:2];
          wdata_d = sel_wdata;
          oor_d   = |sel_addr[31:AW+2];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      oor_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      oor_q   <= oor_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // The strobe is gated by resetn so a reset in ISSUE cannot let a write land.
  logic in_issue, in_wait, rd_ok;
  always_comb begin
    in_issue  = (state_q == S_ISSUE);
    in_wait   = (state_q == S_WAIT);
    rd_ok     = in_wait && !oor_q && !we_q;
    gnt0      = in_issue && !owner_q;
    gnt1      = in_issue && owner_q;
    mem_en    = in_issue && !oor_q && resetn;
    mem_we    = mem_en && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    done0     = in_wait && !owner_q;
    done1     = in_wait && owner_q;
    err0      = done0 && oor_q;
    err1      = done1 && oor_q;
    rdata0    = (rd_ok && !owner_q) ? mem_rdata : 32'h0;
    rdata1    = (rd_ok && owner_q) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a transaction-level model checked every
// cycle, plus literal expectations for each scenario.
module tb_dmem_arbiter;

  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          req0, req1, we0, we1;
  logic [31:0]   addr0, addr1, wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0]   rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  always #5 clock = ~clock;

  dmem_arbiter #(.AW(AW)) dut (
    .clock(clock), .resetn(resetn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port memory standing in for scdatamem: data returns the cycle after mem_en.
  logic [31:0] mem [0:31];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, wanted %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Model: phase 0 idle, 1 access being issued, 2 completion being returned.
  int          phase = 0;
  bit          prefer_zero = 1'b1;
  int          m_pick;
  bit          m_owner, m_we, m_oor;
  int          m_word;
  logic [31:0] m_a, m_wdata;
  logic [31:0] m_rd = 32'h0;
  logic [31:0] shadow [0:31];

  always @(posedge clock) begin
    if (!resetn) begin
      phase = 0;
      prefer_zero = 1'b1;
    end else if (phase == 1) begin
      if (!m_oor) begin
        if (m_we) shadow[m_word] = m_wdata;
        else      m_rd = shadow[m_word];
      end
      phase = 2;
    end else if (req0 || req1) begin
      m_pick      = (req0 && req1) ? (prefer_zero ? 0 : 1) : (req1 ? 1 : 0);
      prefer_zero = (m_pick == 1);
      m_owner     = (m_pick == 1);
      m_we        = m_owner ? we1 : we0;
      m_a         = m_owner ? addr1 : addr0;
      m_wdata     = m_owner ? wdata1 : wdata0;
      m_oor       = (m_a >= 32'(1 << (AW + 2)));
      m_word      = int'((m_a / 4) % 32);
      phase       = 1;
    end else begin
      phase = 0;
    end
  end

  bit check_en = 1'b0;
  bit x_iss, x_done;
  always @(negedge clock) begin
    if (check_en) begin
      x_iss  = (phase == 1);
      x_done = (phase == 2);
      checkBit("m_gnt0", gnt0, x_iss && !m_owner);
      checkBit("m_gnt1", gnt1, x_iss && m_owner);
      checkBit("m_mem_en", mem_en, x_iss && !m_oor && resetn);
      checkBit("m_mem_we", mem_we, x_iss && !m_oor && resetn && m_we);
      if (x_iss) begin
        checkOutput("m_mem_addr", {27'b0, mem_addr}, 32'(m_word));
        checkOutput("m_mem_wdata", mem_wdata, m_wdata);
      end
      checkBit("m_done0", done0, x_done && !m_owner);
      checkBit("m_done1", done1, x_done && m_owner);
      checkBit("m_err0", err0, x_done && !m_owner && m_oor);
      checkBit("m_err1", err1, x_done && m_owner && m_oor);
      checkOutput("m_rdata0", rdata0, (x_done && !m_owner && !m_oor && !m_we) ? m_rd : 32'h0);
      checkOutput("m_rdata1", rdata1, (x_done && m_owner && !m_oor && !m_we) ? m_rd : 32'h0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkBit({tag, "_gnt0"}, gnt0, 1'b0);
    checkBit({tag, "_gnt1"}, gnt1, 1'b0);
    checkBit({tag, "_done0"}, done0, 1'b0);
    checkBit({tag, "_done1"}, done1, 1'b0);
    checkBit({tag, "_err0"}, err0, 1'b0);
    checkBit({tag, "_err1"}, err1, 1'b0);
    checkBit({tag, "_mem_en"}, mem_en, 1'b0);
    checkBit({tag, "_mem_we"}, mem_we, 1'b0);
    checkOutput({tag, "_mem_addr"}, {27'b0, mem_addr}, 32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    checkOutput({tag, "_rdata0"}, rdata0, 32'h0);
    checkOutput({tag, "_rdata1"}, rdata1, 32'h0);
  endtask

  // Raise a request and return in its ISSUE cycle (bounded wait for the grant).
  task automatic applyStimulus(input bit port, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    bit got = 1'b0;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = port ? gnt1 : gnt0;
    end
    checkBit("gnt_arrived", got, 1'b1);
  endtask

  // Step into the WAIT cycle and withdraw the request there.
  task automatic releaseReq(input bit port);
    tick();
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  int gnt_order[$];
  int gnt_cycle[$];

  initial begin
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    for (int i = 0; i < 32; i++) begin
      mem[i]    = 32'hA000_0000 + 32'(i);
      shadow[i] = 32'hA000_0000 + 32'(i);
    end
    mem[3]    = 32'hDEAD_BEEF;
    shadow[3] = 32'hDEAD_BEEF;

    // Reset, then a single read of word 3 withdrawn in WAIT.
    tick();
    check_en = 1'b1;
    tick();
    checkIdle("reset");
    resetn = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_000C;
    tick();
    checkBit("rd_gnt0", gnt0, 1'b1);
    checkBit("rd_mem_en", mem_en, 1'b1);
    checkOutput("rd_mem_addr", {27'b0, mem_addr}, 32'd3);
    tick();
    req0 = 1'b0;
    checkBit("rd_done0", done0, 1'b1);
    checkOutput("rd_rdata0", rdata0, 32'hDEAD_BEEF);
    checkBit("rd_err0", err0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkBit("withdrawn_mem_en", mem_en, 1'b0);
      checkBit("withdrawn_gnt0", gnt0, 1'b0);
    end

    // Requester 1 writes, requester 0 reads it back.
    applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678);
    checkBit("wr_gnt1", gnt1, 1'b1);
    checkBit("wr_mem_we", mem_we, 1'b1);
    checkOutput("wr_mem_addr", {27'b0, mem_addr}, 32'd4);
    checkOutput("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    releaseReq(1'b1);
    checkBit("wr_done1", done1, 1'b1);
    checkOutput("wr_rdata1", rdata1, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    releaseReq(1'b0);
    checkBit("rb_done0", done0, 1'b1);
    checkOutput("rb_rdata0", rdata0, 32'h1234_5678);
    tick();

    // Contention from reset: both hold requests for 8 transactions.
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0004;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0008;
    for (int c = 1; c <= 15; c++) begin
      tick();
      checkBit("dual_gnt", gnt0 & gnt1, 1'b0);
      if (gnt0) begin gnt_order.push_back(0); gnt_cycle.push_back(c); end
      if (gnt1) begin gnt_order.push_back(1); gnt_cycle.push_back(c); end
    end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("rr_count", 32'(gnt_order.size()), 32'd8);
    for (int i = 0; i < gnt_order.size(); i++) begin
      checkOutput("rr_order", 32'(gnt_order[i]), 32'(i % 2));
      if (i > 0) checkOutput("rr_spacing", 32'(gnt_cycle[i] - gnt_cycle[i-1]), 32'd2);
    end
    tick();

    // Out-of-range write and read.
    applyStimulus(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D);
    checkBit("oor_gnt0", gnt0, 1'b1);
    checkBit("oor_mem_en", mem_en, 1'b0);
    checkBit("oor_mem_we", mem_we, 1'b0);
    releaseReq(1'b0);
    checkBit("oor_done0", done0, 1'b1);
    checkBit("oor_err0", err0, 1'b1);
    checkOutput("oor_rdata0", rdata0, 32'h0);
    tick();
    checkOutput("oor_mem0", mem[0], 32'hA000_0000);
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    releaseReq(1'b1);
    checkBit("oor_err1", err1, 1'b1);
    checkOutput("oor_rdata1", rdata1, 32'h0);
    tick();

    // Reset in the ISSUE cycle of a write to word 2.
    applyStimulus(1'b0, 1'b1, 32'h0000_0008, 32'h5555_5555);
    resetn = 1'b0;
    req0 = 1'b0;
    tick();
    checkIdle("midrst");
    tick();
    checkOutput("midrst_mem2", mem[2], 32'hA000_0002);
    resetn = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0004;
    tick();
    checkBit("midrst_tie_gnt0", gnt0, 1'b1);
    checkBit("midrst_tie_gnt1", gnt1, 1'b0);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
